// File: rtl/sync_updown_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package sync_updown_counter_pkg;

    // Direction encoding on the up_down input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Behaviour at a count bound.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Highest legal count value (MODULUS-1). The caller narrows it to WIDTH bits.
    // When MODULUS = 2**WIDTH this becomes all-ones, so no wider constant is needed.
    function automatic logic [31:0] terminal_value(input int unsigned modulus);
        return 32'(modulus - 32'd1);
    endfunction

endpackage

// File: rtl/sync_counter_next.sv
// Next-state logic for the up/down counter.
// Resolves load, count and hold into the next count and wrap flag.
// Also drives the zero-latency terminal-count output used for cascading.
module sync_counter_next
    import sync_updown_counter_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int          SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             c_enable,
    output logic [WIDTH-1:0] next_q,
    output logic             next_wrap,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(terminal_value(MODULUS));
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             at_top_s;
    logic             at_zero_s;
    logic [WIDTH-1:0] load_q_s;
    logic [WIDTH-1:0] up_bound_q_s;
    logic [WIDTH-1:0] down_bound_q_s;

    assign at_top_s  = (q == TERM);
    assign at_zero_s = (q == ZERO);

    // Out-of-range load values clamp to the top of the count range.
    assign load_q_s = (d_in > TERM) ? TERM : d_in;

    // Enabled and sitting at the bound the current direction is heading for.
    assign tc = c_enable & (((up_down == DIR_UP) & at_top_s) |
                            ((up_down == DIR_DOWN) & at_zero_s));

    // Where a bound event leaves the count: stay put, or jump to the opposite bound.
    always_comb begin
        case (SATURATE)
            MODE_SAT: begin
                up_bound_q_s   = q;
                down_bound_q_s = q;
            end
            MODE_WRAP: begin
                up_bound_q_s   = ZERO;
                down_bound_q_s = TERM;
            end
            default: begin
                up_bound_q_s   = ZERO;
                down_bound_q_s = TERM;
            end
        endcase
    end

    // Priority: load over count over hold. A wrap is flagged only on a bound event.
    always_comb begin
        next_q    = q;
        next_wrap = 1'b0;
        if (load) begin
            next_q    = load_q_s;
            next_wrap = 1'b0;
        end else if (c_enable) begin
            case (up_down)
                DIR_UP: begin
                    if (at_top_s) begin
                        next_q    = up_bound_q_s;
                        next_wrap = 1'b1;
                    end else begin
                        next_q    = q + ONE;
                        next_wrap = 1'b0;
                    end
                end
                DIR_DOWN: begin
                    if (at_zero_s) begin
                        next_q    = down_bound_q_s;
                        next_wrap = 1'b1;
                    end else begin
                        next_q    = q - ONE;
                        next_wrap = 1'b0;
                    end
                end
                default: begin
                    next_q    = q;
                    next_wrap = 1'b0;
                end
            endcase
        end else begin
            next_q    = q;
            next_wrap = 1'b0;
        end
    end

endmodule

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with load, wrap/saturate mode,
// cascadable terminal count and a registered one-cycle wrap pulse.
module sync_updown_counter
    import sync_updown_counter_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int          SATURATE = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             c_enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] next_q_s;
    logic             next_wrap_s;

    sync_counter_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .q         (q_r),
        .up_down   (up_down),
        .load      (load),
        .d_in      (d_in),
        .c_enable  (c_enable),
        .next_q    (next_q_s),
        .next_wrap (next_wrap_s),
        .tc        (tc)
    );

    // Count and wrap-pulse registers; clear zeroes both without waiting for an edge.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q_r    <= {WIDTH{1'b0}};
            wrap_r <= 1'b0;
        end else begin
            q_r    <= next_q_s;
            wrap_r <= next_wrap_s;
        end
    end

    assign Q    = q_r;
    assign wrap = wrap_r;

endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
Parametrised synchronous counter; next generation of the 4-bit enable/clear counter. Adds:
- configurable width and modulus
- up/down direction
- synchronous parallel load
- wrap or saturate mode
- cascadable terminal-count output and a registered wrap pulse

Used as the general-purpose event/timer counter in the datapath and cascaded to build wider counters.

Parameters:
WIDTH, 4, counter width in bits (>= 2).
MODULUS, 16, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at bounds; 1 = hold at bounds.

Ports:
clock  input  1  rising-edge clock
clear  input  1  asynchronous active-low reset; 0 forces reset state immediately
c_enable  input  1  count enable; count advances only when 1
up_down  input  1  direction: 1 = up, 0 = down
load  input  1  synchronous parallel load request
d_in  input  WIDTH  load value
Q  output  WIDTH  registered count value
tc  output  1  terminal count, combinational: c_enable & at-bound-in-current-direction
wrap  output  1  registered one-cycle pulse: counter wrapped, or hit saturation bound, on the previous edge

Behaviour:
- Reset (clear=0, asynchronous): Q=0, wrap=0. tc follows its equation with Q=0: 1 only if c_enable=1 and up_down=0.
- While clear=0, all inputs are ignored. Release is synchronous in effect: the first count/load happens on the first rising edge with clear=1.
- Priority per rising edge: clear > load > c_enable > hold.
- Load (load=1, regardless of c_enable):
  - Q <= d_in if d_in <= MODULUS-1, else Q <= MODULUS-1 (clamp).
  - wrap <= 0.
- Count (load=0, c_enable=1), up:
  - Q < MODULUS-1: Q <= Q+1.
  - Q = MODULUS-1, SATURATE=0: Q <= 0, wrap <= 1.
  - Q = MODULUS-1, SATURATE=1: Q holds, wrap <= 1.
- Count (load=0, c_enable=1), down:
  - Q > 0: Q <= Q-1.
  - Q = 0, SATURATE=0: Q <= MODULUS-1, wrap <= 1.
  - Q = 0, SATURATE=1: Q holds, wrap <= 1.
- Hold (load=0, c_enable=0): Q holds, wrap <= 0.
- wrap is a pulse, high for exactly one cycle after each bound event. In saturate mode it re-asserts on every enabled cycle spent at the bound.
- tc = c_enable & ((up_down & Q==MODULUS-1) | (~up_down & Q==0)). Purely combinational, zero latency, so a downstream stage can use it as its c_enable when cascading.
- Latency: Q reflects the load or count one clock after the edge at which the request is sampled.
- Direction change takes effect on the same edge it is sampled; there is no turnaround cycle.
- Arithmetic:
  - Next-state comparisons use WIDTH-bit unsigned values.
  - When MODULUS = 2**WIDTH, the up path must not overflow the comparison constant: compare against all-ones.
- Q never leaves 0..MODULUS-1 after reset, under any input sequence.
- Mid-operation reset: clear asserted between edges zeroes Q immediately, without waiting for a clock edge. wrap clears in the same instant.

Decomposition:
- Shared package holds:
  - direction constants DIR_UP=1, DIR_DOWN=0
  - mode constants MODE_WRAP=0, MODE_SAT=1
  - a function computing the terminal value MODULUS-1 in WIDTH bits
- One sub-module is natural: sync_counter_next, combinational. Inputs Q, up_down, load, d_in, c_enable; outputs next_q, next_wrap, tc.
- The top holds only the registers, with async active-low clear.

Test Plan:
1. Reset and up wrap. WIDTH=4, MODULUS=10, SATURATE=0. clear=0 then 1 at t=5, c_enable=1, up_down=1. Expect:
   - Q: 0,1,...,9,0
   - tc=1 while Q=9
   - wrap=1 only in the cycle after 9→0
2. Down wrap, same config. Load 2, then count down. Expect:
   - Q: 2,1,0,9,8
   - tc=1 while Q=0
   - wrap pulses once, after 0→9
3. Saturate. SATURATE=1, MODULUS=10, count up from 7. Expect:
   - Q: 7,8,9,9,9
   - wrap=1 on each enabled cycle at 9
   - with up_down=0, Q then moves 9→8
4. Load priority and clamping:
   - load=1, c_enable=1, d_in=5 → Q=5 next cycle, no increment.
   - d_in=12 with MODULUS=10 → Q=9.
   - load with c_enable=0 still loads.
5. Enable hold and direction switch:
   - c_enable=0 at Q=4 for 3 cycles → Q stays 4, tc=0, wrap=0.
   - Then up_down toggles each enabled cycle → Q: 5,4,5.
6. Async reset mid-count and cascade:
   - clear pulsed low between edges at Q=6 → Q=0 before the next edge.
   - Two instances WIDTH=4, MODULUS=16, upper c_enable = lower tc. The pair counts 0x00..0xFF; the upper stage increments only when the lower goes F→0.
